// File: rtl/uart_loader_pkg.sv
// Shared loader types: FSM state encoding, default framing bytes and the 16-bit word-count type.
package uart_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN0,
    LEN1,
    DATA,
    CSUM,
    RESP,
    DONE
  } state_t;

  localparam logic [7:0] DEF_MAGIC = 8'hA5;
  localparam logic [7:0] DEF_ACK   = 8'h06;
  localparam logic [7:0] DEF_NAK   = 8'h15;

  typedef logic [15:0] wcount_t;

endpackage

// File: rtl/uart_loader_if.sv
// UART byte-stream link: RX pop side (r_*) and TX push side (w_*); master is the loader, slave the UART.
interface uart_loader_if;

  logic [7:0] r_data;
  logic       r_ready;
  logic       r_valid;
  logic [7:0] w_data;
  logic       w_valid;
  logic       w_ready;

  modport master (
    input  r_data, r_ready, w_ready,
    output r_valid, w_data, w_valid
  );

  modport slave (
    output r_data, r_ready, w_ready,
    input  r_valid, w_data, w_valid
  );

endinterface

// File: rtl/uart_loader_word_assembler.sv
// Places bytes little-endian into a 32-bit word; word_we pulses the cycle after the 4th byte.
// No backpressure of its own: bytes are accepted whenever byte_vld is high.
module uart_loader_word_assembler (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        byte_vld,
  input  logic [7:0]  byte_dat,
  output logic [31:0] word,
  output logic        word_we
);

  logic [1:0] idx;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx     <= '0;
      word    <= '0;
      word_we <= 1'b0;
    end else begin
      word_we <= byte_vld && (idx == 2'd3);
      if (clear) begin
        idx <= '0;
      end else if (byte_vld) begin
        word[{idx, 3'b000} +: 8] <= byte_dat;
        idx                      <= idx + 2'd1;
      end
    end
  end

endmodule

// File: rtl/uart_program_loader.sv
// Boot loader: MAGIC | N (le16) | N words (le32) from UART RX into imem, ACK/NAK on TX, core held in reset until ACK taken.
// Trailing checksum byte and NAK path exist only with UART_LOADER_CHECKSUM_EN; stalls indefinitely on empty RX or full TX.
module uart_program_loader
  import uart_loader_pkg::*;
#(
  parameter int         ADDR_WIDTH = 12,
  parameter logic [7:0] MAGIC      = DEF_MAGIC,
  parameter logic [7:0] ACK_BYTE   = DEF_ACK,
  parameter logic [7:0] NAK_BYTE   = DEF_NAK
) (
  input  logic                  CLK,
  input  logic                  RST,
  uart_loader_if.master         uart,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  core_rst_n,
  output logic                  load_done
);

  state_t     state, state_nxt;
  wcount_t    n_words, word_cnt;
  logic       rx_pop_q, rx_take, tx_take, start, last_word, verdict, resp_ack;
  logic [7:0] w_data_q;

`ifdef UART_LOADER_CHECKSUM_EN
  localparam state_t POST_DATA = CSUM;
`else
  localparam state_t POST_DATA = RESP;
`endif

  // Never pop on back-to-back cycles so the upstream FIFO has a cycle to advance.
  assign uart.r_valid = RST && (state != RESP) && uart.r_ready && !rx_pop_q;
  assign rx_take      = uart.r_valid;
  assign uart.w_valid = (state == RESP);
  assign uart.w_data  = w_data_q;
  assign tx_take      = uart.w_valid && uart.w_ready;
  assign start        = rx_take && (uart.r_data == MAGIC) && (state == IDLE || state == DONE);
  assign last_word    = (word_cnt + 16'd1) == n_words;
  assign core_rst_n   = (state == DONE);
  assign load_done    = (state == DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = LEN0;
      LEN0:    if (rx_take) state_nxt = LEN1;
      LEN1:    if (rx_take) state_nxt = ({uart.r_data, n_words[7:0]} == 16'd0) ? POST_DATA : DATA;
      DATA:    if (mem_we && last_word) state_nxt = POST_DATA;
      CSUM:    if (rx_take) state_nxt = RESP;
      RESP:    if (tx_take) state_nxt = resp_ack ? DONE : IDLE;
      DONE:    if (start) state_nxt = LEN0;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state    <= IDLE;
      rx_pop_q <= 1'b0;
      n_words  <= '0;
      word_cnt <= '0;
      mem_addr <= '0;
      w_data_q <= '0;
      resp_ack <= 1'b0;
    end else begin
      state    <= state_nxt;
      rx_pop_q <= rx_take;
      if (start) begin
        word_cnt <= '0;
        mem_addr <= '0;
      end
      if (state == LEN0 && rx_take) n_words[7:0]  <= uart.r_data;
      if (state == LEN1 && rx_take) n_words[15:8] <= uart.r_data;
      if (mem_we) begin
        word_cnt <= word_cnt + 16'd1;
        mem_addr <= mem_addr + ADDR_WIDTH'(1);
      end
      if (state != RESP && state_nxt == RESP) begin
        w_data_q <= verdict ? ACK_BYTE : NAK_BYTE;
        resp_ack <= verdict;
      end
    end
  end

`ifdef UART_LOADER_CHECKSUM_EN
  logic [7:0] cks;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      cks <= '0;
    end else if (start) begin
      cks <= '0;
    end else if (state == DATA && rx_take) begin
      cks <= cks + uart.r_data;
    end
  end

  // Only consulted on the CSUM -> RESP transition, where r_data is the checksum byte.
  assign verdict = (uart.r_data == cks);
`else
  assign verdict = 1'b1;
`endif

  uart_loader_word_assembler u_asm (
    .clk      (CLK),
    .rst_n    (RST),
    .clear    (start),
    .byte_vld (rx_take && state == DATA),
    .byte_dat (uart.r_data),
    .word     (mem_wdata),
    .word_we  (mem_we)
  );

endmodule

// File: tb/tb_uart_program_loader.sv
// Directed bench for uart_program_loader: RX FIFO model, write/TX scoreboard, immediate-assertion checks.
module tb_uart_program_loader;

  localparam int AW = 4;

  logic          CLK;
  logic          RST;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          core_rst_n;
  logic          load_done;

  uart_loader_if uart();

  uart_program_loader #(.ADDR_WIDTH(AW)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .uart       (uart),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .core_rst_n (core_rst_n),
    .load_done  (load_done)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  logic [7:0]     rx_q[$];
  logic [AW+31:0] exp_wr_q[$];
  logic [7:0]     exp_tx_q[$];
  int             n_tests = 0;
  int             n_fail = 0;
  int             tx_cnt = 0;
  int             fall_seen = 0;
  logic [7:0]     tb_cks;
  logic [AW-1:0]  tb_addr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic send_hdr(input logic [15:0] n);
    rx_q.push_back(8'hA5);
    rx_q.push_back(n[7:0]);
    rx_q.push_back(n[15:8]);
    tb_cks  = 8'h00;
    tb_addr = '0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      rx_q.push_back(w[8*i +: 8]);
      tb_cks = tb_cks + w[8*i +: 8];
    end
    exp_wr_q.push_back({tb_addr, w});
    tb_addr = tb_addr + 1'b1;
  endtask

  task automatic send_end();
`ifdef UART_LOADER_CHECKSUM_EN
    rx_q.push_back(tb_cks);
`endif
    exp_tx_q.push_back(8'h06);
  endtask

  task automatic wait_drain(input string tag);
    int cyc;
    cyc = 0;
    while ((rx_q.size() != 0 || exp_wr_q.size() != 0 || exp_tx_q.size() != 0) && cyc < 3000) begin
      tick(1);
      cyc++;
    end
    check({tag, "_drain_in_time"}, 32'(cyc < 3000), 32'd1);
    tick(3);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_r_valid"},    32'(uart.r_valid), 32'd0);
    check({tag, "_w_valid"},    32'(uart.w_valid), 32'd0);
    check({tag, "_w_data"},     32'(uart.w_data),  32'd0);
    check({tag, "_mem_we"},     32'(mem_we),       32'd0);
    check({tag, "_mem_addr"},   32'(mem_addr),     32'd0);
    check({tag, "_mem_wdata"},  mem_wdata,         32'd0);
    check({tag, "_core_rst_n"}, 32'(core_rst_n),   32'd0);
    check({tag, "_load_done"},  32'(load_done),    32'd0);
  endtask

  // UART RX FIFO model: presents the queue head, pops it on an accepted handshake.
  initial begin : rx_feeder
    logic took;
    uart.r_ready = 1'b0;
    uart.r_data  = 8'h00;
    forever begin
      @(posedge CLK);
      took = uart.r_valid && uart.r_ready;
      #1;
      if (took && rx_q.size() != 0) void'(rx_q.pop_front());
      uart.r_ready = (rx_q.size() != 0);
      uart.r_data  = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
    end
  end

  initial begin : monitor
    logic           prev_rvalid, prev_ack, prev_core, magic_in_done;
    logic [AW+31:0] e;
    prev_rvalid = 1'b0; prev_ack = 1'b0; prev_core = 1'b0; magic_in_done = 1'b0;
    forever begin
      @(negedge CLK);
      if (magic_in_done) begin
        check("reload_core_rst_fall", 32'(core_rst_n), 32'd0);
        check("reload_load_done_fall", 32'(load_done), 32'd0);
        fall_seen++;
      end
      if (prev_ack) check("core_rst_after_ack", 32'(core_rst_n), 32'd1);
      if (core_rst_n && !prev_core) check("core_rst_rise_needs_ack", 32'(prev_ack), 32'd1);
      if (uart.r_valid) begin
        check("r_valid_gap", 32'(prev_rvalid), 32'd0);
        check("r_valid_needs_ready", 32'(uart.r_ready), 32'd1);
      end
      if (mem_we) begin
        check("write_while_core_run", 32'(core_rst_n), 32'd0);
        if (exp_wr_q.size() == 0) begin
          check("unexpected_write", 32'(exp_wr_q.size()), 32'd1);
        end else begin
          e = exp_wr_q.pop_front();
          check("wr_addr", 32'(mem_addr), 32'(e[AW+31:32]));
          check("wr_data", mem_wdata, e[31:0]);
        end
      end
      if (uart.w_valid && uart.w_ready) begin
        tx_cnt++;
        if (exp_tx_q.size() == 0) check("unexpected_tx", 32'(exp_tx_q.size()), 32'd1);
        else check("tx_byte", 32'(uart.w_data), 32'(exp_tx_q.pop_front()));
      end
      prev_ack      = uart.w_valid && uart.w_ready && (uart.w_data == 8'h06);
      magic_in_done = uart.r_valid && uart.r_ready && (uart.r_data == 8'hA5) && load_done;
      prev_rvalid   = uart.r_valid;
      prev_core     = core_rst_n;
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int bad;
    int tx_before;
    int cyc;
    RST          = 1'b0;
    uart.w_ready = 1'b1;
    tb_cks       = 8'h00;
    tb_addr      = '0;
    tick(3);
    check_reset("por");
    RST = 1'b1;

    // Leading garbage in IDLE, then a reply held under TX backpressure.
    uart.w_ready = 1'b0;
    rx_q.push_back(8'h00); rx_q.push_back(8'hFF); rx_q.push_back(8'h3C);
    send_hdr(16'd1);
    send_word(32'hDEADBEEF);
    send_end();
    cyc = 0;
    while (uart.w_valid !== 1'b1 && cyc < 1000) begin
      tick(1);
      cyc++;
    end
    check("bp_resp_reached", 32'(uart.w_valid), 32'd1);
    bad = 0;
    repeat (50) begin
      tick(1);
      if (uart.w_valid !== 1'b1 || uart.w_data !== 8'h06 || core_rst_n !== 1'b0) bad++;
    end
    check("bp_hold_stable", 32'(bad), 32'd0);
    tx_before    = tx_cnt;
    uart.w_ready = 1'b1;
    wait_drain("garbage");
    check("bp_accept_once", 32'(tx_cnt - tx_before), 32'd1);
    check("garbage_w_valid_dropped", 32'(uart.w_valid), 32'd0);
    check("garbage_load_done", 32'(load_done), 32'd1);
    check("garbage_core_rst_n", 32'(core_rst_n), 32'd1);
    check("garbage_addr", 32'(mem_addr), 32'd1);

    // Reload from DONE.
    fall_seen = 0;
    send_hdr(16'd1);
    send_word(32'h12345678);
    send_end();
    wait_drain("reload");
    check("reload_fall_seen", 32'(fall_seen), 32'd1);
    check("reload_load_done", 32'(load_done), 32'd1);
    check("reload_addr", 32'(mem_addr), 32'd1);

`ifdef UART_LOADER_CHECKSUM_EN
    // Bad checksum: word still written, NAK, core stays in reset.
    send_hdr(16'd1);
    send_word(32'h04030201);
    rx_q.push_back(8'h00);
    exp_tx_q.push_back(8'h15);
    wait_drain("nak");
    check("nak_core_rst_n", 32'(core_rst_n), 32'd0);
    check("nak_load_done", 32'(load_done), 32'd0);
`endif

    // Basic two-word load.
    send_hdr(16'd2);
    send_word(32'h00000013);
    send_word(32'h00100093);
    send_end();
    wait_drain("basic");
    check("basic_core_rst_n", 32'(core_rst_n), 32'd1);
    check("basic_addr", 32'(mem_addr), 32'd2);

    // Reset after the second data byte, then a clean frame.
    rx_q.push_back(8'hA5); rx_q.push_back(8'h01); rx_q.push_back(8'h00);
    rx_q.push_back(8'h11); rx_q.push_back(8'h22);
    cyc = 0;
    while (rx_q.size() != 0 && cyc < 200) begin
      tick(1);
      cyc++;
    end
    tick(3);
    check("partial_consumed", 32'(rx_q.size()), 32'd0);
    check("partial_word_lo", 32'(mem_wdata[15:0]), 32'h2211);
    RST = 1'b0;
    tick(1);
    check_reset("midframe");
    RST = 1'b1;
    send_hdr(16'd1);
    send_word(32'hCAFEF00D);
    send_end();
    wait_drain("after_reset");
    check("after_reset_addr", 32'(mem_addr), 32'd1);
    check("after_reset_load_done", 32'(load_done), 32'd1);

    // 18 words through a 16-entry address space; data contains the MAGIC byte.
    send_hdr(16'd18);
    for (int i = 0; i < 18; i++) send_word(32'hA5C30000 + 32'(i));
    send_end();
    wait_drain("wrap");
    check("wrap_addr", 32'(mem_addr), 32'd2);
    check("wrap_load_done", 32'(load_done), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_program_loader.md
Name: uart_program_loader

Overview:
Host-facing boot loader that consumes the UART byte-stream interface as its reader and writer.
- Pops received bytes and parses a framed program image.
- Assembles little-endian 32-bit words and writes them sequentially into instruction memory.
- Replies with a one-byte ACK/NAK through the UART TX interface.
- Holds the RV32I core in reset until a load completes successfully.

Parameters:
ADDR_WIDTH, 12, instruction-memory word-address width; writes wrap modulo 2^ADDR_WIDTH.
MAGIC, 8'hA5, frame start byte.
ACK_BYTE, 8'h06, reply on successful load.
NAK_BYTE, 8'h15, reply on checksum failure.

Ports:
CLK  input  1  clock.
RST  input  1  reset; synchronous, active-low.
r_data  input  8  RX byte from the UART.
r_ready  input  1  RX byte available.
r_valid  output  1  RX pop request.
w_data  output  8  TX byte to the UART.
w_valid  output  1  TX write request.
w_ready  input  1  TX space available.
mem_we  output  1  instruction-memory write strobe, one cycle per word.
mem_addr  output  ADDR_WIDTH  word address.
mem_wdata  output  32  word data.
core_rst_n  output  1  core reset; low = core held in reset.
load_done  output  1  high after an ACK has been accepted by the UART.

Behaviour:
Reset values (all outputs):
- r_valid=0, w_valid=0, w_data=0, mem_we=0, mem_addr=0, mem_wdata=0, core_rst_n=0, load_done=0.
- state=IDLE, byte index=0, word counter=0, checksum=0.

RX handshake:
- A byte is consumed in a cycle where r_valid&&r_ready; r_data is sampled in that cycle.
- r_valid is asserted only when r_ready=1.
- r_valid is never high in two consecutive cycles, so the FIFO has one cycle to advance.

TX handshake:
- w_valid and w_data are held stable until w_valid&&w_ready.
- w_valid drops in the cycle after acceptance.

State machine:
- IDLE: any byte != MAGIC is discarded. MAGIC -> LEN0, clear counters, checksum=0, mem_addr=0.
- LEN0: low byte of 16-bit word count N -> LEN1.
- LEN1: high byte of N. If N==0 -> CSUM (macro on) or RESP (macro off); otherwise -> DATA.
- DATA:
  - Bytes fill mem_wdata[7:0], [15:8], [23:16], [31:24] in that order.
  - On the 4th byte, mem_we pulses for exactly one cycle on the following cycle, with the current mem_addr.
  - mem_addr increments in the cycle after the pulse, truncated to ADDR_WIDTH (wraps from 2^ADDR_WIDTH-1 to 0).
  - After word N is written -> CSUM or RESP.
- CSUM: one byte received and compared -> RESP.
- RESP: drive w_data=ACK_BYTE (or NAK_BYTE) with w_valid. On acceptance:
  - ACK -> DONE, with core_rst_n=1 and load_done=1 from the next cycle.
  - NAK -> IDLE, with core_rst_n remaining 0.
- DONE: waits for r_ready. A MAGIC byte restarts the load: core_rst_n=0 and load_done=0 next cycle, then -> LEN0. Other bytes are discarded.

Boundary conditions:
- No timeout. A stalled frame waits indefinitely; only reset aborts it.
- Reset mid-frame discards any partial word and returns all state to reset values. Memory contents already written are not cleared.
- The loader never writes memory while core_rst_n=1.
- N=65535 with wrap: later words overwrite earlier ones; no error is flagged.

Optional Feature:
Macro: UART_LOADER_CHECKSUM_EN.
- Defined:
  - Frame ends with one checksum byte equal to the 8-bit sum (mod 256) of all 4N data bytes.
  - Match -> ACK_BYTE; mismatch -> NAK_BYTE.
  - The checksum register resets to 0 at MAGIC.
- Undefined:
  - No checksum byte is expected; CSUM state and the adder are absent.
  - The reply is always ACK_BYTE and NAK_BYTE is unused.

Decomposition:
Package uart_loader_pkg contains:
- state enum: IDLE, LEN0, LEN1, DATA, CSUM, RESP, DONE;
- default MAGIC/ACK/NAK constants;
- 16-bit word-count type.

One natural sub-module, uart_loader_word_assembler:
- byte-index counter, 32-bit shift/place register, and mem_we pulse generation;
- the top level keeps the FSM, both handshakes, the address counter and the checksum.

Test Plan:
- Basic load: A5 02 00 | 13 00 00 00 | 93 00 10 00 (+ checksum B6 if macro on) -> mem writes (0,0x00000013), (1,0x00100093); TX emits 06; core_rst_n rises only after TX acceptance.
- Leading garbage: 00 FF 3C before A5 01 00 EF BE AD DE -> garbage ignored; single write (0,0xDEADBEEF); ACK.
- Backpressure: w_ready held low for 50 cycles in RESP -> w_valid and w_data=06 stable throughout; accepted exactly once.
- Checksum failure (macro on): A5 01 00 01 02 03 04 00 -> word 0x04030201 written; TX emits 15; core_rst_n stays 0; a following correct frame yields ACK.
- Reset mid-frame: RST low for 1 cycle after the 2nd data byte -> all outputs at reset values; a new frame starts from address 0 with no stale bytes.
- Reload: after DONE, send A5 01 00 78 56 34 12 -> core_rst_n falls the cycle after MAGIC is consumed; write (0,0x12345678); ACK; core_rst_n rises again.
